ipq_fetch_unit: RTL and testbench

// Consumer of the bus control unit's 8-byte instruction prefetch queue. Owns the

---
 rtl/ipq_fetch_if.sv | 35 +++
 rtl/ipq_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_ipq_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipq_fetch_if.sv
// rtl/ipq_fetch_if.sv - fetch unit bundle: BCU prefetch queue, branch redirect, opcode classifier, EU record
interface ipq_fetch_if;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;
  logic [15:0]     ipq_head;
  logic            pfp_set;
  logic            branch_req;
  logic [15:0]     branch_ip;
  logic [7:0]      op_out;
  logic            cls_modrm;
  logic [1:0]      cls_imm;
  logic            instr_valid;
  logic            instr_ready;
  logic [15:0]     instr_ip;
  logic [3:0]      instr_len;
  logic [2:0]      seg_ovr;
  logic [2:0]      rep_pfx;
  logic            lock_pfx;
  logic [7:0]      modrm;
  logic [15:0]     disp;
  logic [15:0]     imm;
  logic            pfx_fault;

  modport master (
    input  ipq, ipq_len, branch_req, branch_ip, cls_modrm, cls_imm, instr_ready,
    output ipq_head, pfp_set, op_out, instr_valid, instr_ip, instr_len,
           seg_ovr, rep_pfx, lock_pfx, modrm, disp, imm, pfx_fault
  );

  modport slave (
    output ipq, ipq_len, branch_req, branch_ip, cls_modrm, cls_imm, instr_ready,
    input  ipq_head, pfp_set, op_out, instr_valid, instr_ip, instr_len,
           seg_ovr, rep_pfx, lock_pfx, modrm, disp, imm, pfx_fault
  );
endinterface

// File: rtl/ipq_fetch_unit.sv
// rtl/ipq_fetch_unit.sv - instruction fetch: consumes the prefetch queue one byte per ce_1 step
// and assembles prefixes, opcode, ModR/M, displacement and immediate into one record.
module ipq_fetch_unit #(
  parameter logic [15:0] RESET_IP = 16'h0000,
  parameter int          PFX_MAX  = 4
) (
  input logic        clk,
  input logic        reset,
  input logic        ce_1,
  ipq_fetch_if.master bus
);

  typedef enum logic [2:0] {S_OP, S_MODRM, S_DLO, S_DHI, S_ILO, S_IHI, S_HOLD} state_t;
  state_t state, state_d;

  logic [15:0] head_q;
  logic        pfp_q;
  logic        fault_q;
  logic [15:0] ip_q;
  logic [3:0]  len_q;
  logic [2:0]  seg_q;
  logic [2:0]  rep_q;
  logic        lock_q;
  logic [7:0]  op_q;
  logic [7:0]  modrm_q;
  logic [15:0] disp_q;
  logic [15:0] imm_q;
  logic [3:0]  pfx_cnt;
  logic [1:0]  isz_q;
  logic [1:0]  dsz_q;

  logic [7:0] b;
  logic       take;
  logic       clr;
  logic       is_seg;
  logic       is_rep;
  logic       is_lock;
  logic       is_pfx;
  logic [1:0] cls_isz;
  logic [1:0] mrm_dsz;

  always_comb begin
    b       = bus.ipq[head_q[2:0]];
    take    = ce_1 && !bus.branch_req && !pfp_q && (bus.ipq_len != 4'd0) && (state != S_HOLD);
    clr     = ce_1 && (bus.branch_req || ((state == S_HOLD) && bus.instr_ready));
    is_seg  = b inside {8'h26, 8'h2E, 8'h36, 8'h3E};
    is_rep  = b inside {8'hF2, 8'hF3, 8'h64, 8'h65};
    is_lock = (b == 8'hF0);
    is_pfx  = is_seg || is_rep || is_lock;
    cls_isz = (bus.cls_imm == 2'd3) ? 2'd0 : bus.cls_imm;
    case (b[7:6])
      2'b00:   mrm_dsz = (b[2:0] == 3'b110) ? 2'd2 : 2'd0;
      2'b01:   mrm_dsz = 2'd1;
      2'b10:   mrm_dsz = 2'd2;
      default: mrm_dsz = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_OP;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (ce_1 && bus.branch_req) begin
      state_d = S_OP;
    end else if (ce_1 && (state == S_HOLD)) begin
      if (bus.instr_ready) state_d = S_OP;
    end else if (take) begin
      case (state)
        S_OP:    if (!is_pfx) state_d = bus.cls_modrm ? S_MODRM : (cls_isz != 2'd0) ? S_ILO : S_HOLD;
        S_MODRM: state_d = (mrm_dsz != 2'd0) ? S_DLO : (isz_q != 2'd0) ? S_ILO : S_HOLD;
        S_DLO:   state_d = (dsz_q == 2'd2) ? S_DHI : (isz_q != 2'd0) ? S_ILO : S_HOLD;
        S_DHI:   state_d = (isz_q != 2'd0) ? S_ILO : S_HOLD;
        S_ILO:   state_d = (isz_q == 2'd2) ? S_IHI : S_HOLD;
        S_IHI:   state_d = S_HOLD;
        default: state_d = S_OP;
      endcase
    end
  end

  // pfp_set drops on the first ce_1 after it was raised; no byte is taken while it is high
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= RESET_IP;
      pfp_q   <= 1'b1;
      fault_q <= 1'b0;
    end else if (ce_1) begin
      pfp_q <= bus.branch_req;
      if (bus.branch_req)
        head_q <= bus.branch_ip;
      else if (take)
        head_q <= head_q + 16'd1;
      if (take && (state == S_OP) && is_pfx && (int'(pfx_cnt) >= PFX_MAX))
        fault_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ip_q    <= 16'd0;
      len_q   <= 4'd0;
      seg_q   <= 3'd0;
      rep_q   <= 3'd0;
      lock_q  <= 1'b0;
      op_q    <= 8'd0;
      modrm_q <= 8'd0;
      disp_q  <= 16'd0;
      imm_q   <= 16'd0;
      pfx_cnt <= 4'd0;
      isz_q   <= 2'd0;
      dsz_q   <= 2'd0;
    end else if (take) begin
      len_q <= (len_q == 4'hF) ? len_q : len_q + 4'd1;
      case (state)
        S_OP: begin
          if (len_q == 4'd0) ip_q <= head_q;
          if (is_pfx) begin
            if (pfx_cnt != 4'hF) pfx_cnt <= pfx_cnt + 4'd1;
            if (is_seg)  seg_q  <= {1'b1, b[4:3]};
            if (is_rep)  rep_q  <= {1'b1, ~b[7], b[0]};
            if (is_lock) lock_q <= 1'b1;
          end else begin
            op_q  <= b;
            isz_q <= cls_isz;
          end
        end
        S_MODRM: begin
          modrm_q <= b;
          dsz_q   <= mrm_dsz;
        end
        S_DLO:   disp_q       <= {{8{b[7]}}, b};
        S_DHI:   disp_q[15:8] <= b;
        S_ILO:   imm_q        <= {8'd0, b};
        S_IHI:   imm_q[15:8]  <= b;
        default: ;
      endcase
    end
  end

  // While waiting for the opcode the classifier sees the candidate byte so it can answer this step
  assign bus.op_out      = (state == S_OP) ? b : op_q;
  assign bus.ipq_head    = head_q;
  assign bus.pfp_set     = pfp_q;
  assign bus.instr_valid = (state == S_HOLD);
  assign bus.instr_ip    = ip_q;
  assign bus.instr_len   = len_q;
  assign bus.seg_ovr     = seg_q;
  assign bus.rep_pfx     = rep_q;
  assign bus.lock_pfx    = lock_q;
  assign bus.modrm       = modrm_q;
  assign bus.disp        = disp_q;
  assign bus.imm         = imm_q;
  assign bus.pfx_fault   = fault_q;

endmodule

// File: tb/tb_ipq_fetch_unit.sv
// tb/tb_ipq_fetch_unit.sv - directed and randomized checks of ipq_fetch_unit against a byte-stream memory model
module tb_ipq_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  logic ce_1;
  ipq_fetch_if bus ();

  ipq_fetch_unit #(.RESET_IP(16'h0000), .PFX_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ce_1  (ce_1),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] pfx_tab [9] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF2, 8'hF3, 8'h64, 8'h65, 8'hF0};
  logic [7:0] op_tab  [8] = '{8'h90, 8'h8B, 8'hB8, 8'hB0, 8'h81, 8'h83, 8'h6A, 8'h05};

  logic [15:0] exp_ip, exp_disp, exp_imm;
  logic [3:0]  exp_len;
  logic [2:0]  exp_seg, exp_rep;
  logic        exp_lock;
  logic [7:0]  exp_op, exp_modrm;
  logic [15:0] cur;
  logic [15:0] tgt;

  // opcode classifier: {takes ModR/M, immediate size code}
  function automatic logic [2:0] cls_code(input logic [7:0] op);
    case (op)
      8'h8B:   return 3'b1_00;
      8'hB8:   return 3'b0_10;
      8'hB0:   return 3'b0_01;
      8'h81:   return 3'b1_10;
      8'h83:   return 3'b1_01;
      8'h6A:   return 3'b0_01;
      8'h05:   return 3'b0_11;
      default: return 3'b0_00;
    endcase
  endfunction

  always_comb {bus.cls_modrm, bus.cls_imm} = cls_code(bus.op_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present the 8-byte window around the current head as the BCU would, then advance one clock
  task automatic step();
    for (int k = 0; k < 8; k++) begin
      logic [2:0] d;
      d = 3'(k) - bus.ipq_head[2:0];
      bus.ipq[k] = mem[bus.ipq_head + {13'd0, d}];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] a, input logic [63:0] bytes_be, input int n);
    for (int i = 0; i < n; i++) mem[a + 16'(i)] = bytes_be[8*(n-1-i) +: 8];
  endtask

  task automatic take_n(input int n);
    for (int i = 0; i < n; i++) begin
      ce_1 = 1'b1;
      bus.ipq_len = 4'd8;
      step();
    end
  endtask

  task automatic accept();
    ce_1 = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("accept clears valid", bus.instr_valid, 1'b0);
  endtask

  task automatic gen_instr(input logic [15:0] a);
    int n;
    int npfx;
    logic [7:0] pb;
    logic [2:0] cc;
    int dsz;
    int isz;
    logic [15:0] v;
    n = 0;
    exp_ip = a; exp_seg = 3'd0; exp_rep = 3'd0; exp_lock = 1'b0;
    exp_modrm = 8'd0; exp_disp = 16'd0; exp_imm = 16'd0;
    npfx = $urandom_range(0, 4);
    for (int i = 0; i < npfx; i++) begin
      pb = pfx_tab[$urandom_range(0, 8)];
      mem[a + 16'(n)] = pb; n++;
      case (pb)
        8'h26: exp_seg = 3'b100;
        8'h2E: exp_seg = 3'b101;
        8'h36: exp_seg = 3'b110;
        8'h3E: exp_seg = 3'b111;
        8'hF2: exp_rep = 3'b100;
        8'hF3: exp_rep = 3'b101;
        8'h64: exp_rep = 3'b110;
        8'h65: exp_rep = 3'b111;
        default: exp_lock = 1'b1;
      endcase
    end
    exp_op = op_tab[$urandom_range(0, 7)];
    mem[a + 16'(n)] = exp_op; n++;
    cc = cls_code(exp_op);
    isz = (cc[1:0] == 2'd3) ? 0 : int'(cc[1:0]);
    dsz = 0;
    if (cc[2]) begin
      exp_modrm = 8'($urandom);
      mem[a + 16'(n)] = exp_modrm; n++;
      if (exp_modrm[7:6] == 2'b01) dsz = 1;
      else if (exp_modrm[7:6] == 2'b10) dsz = 2;
      else if (exp_modrm[7:6] == 2'b00 && exp_modrm[2:0] == 3'b110) dsz = 2;
    end
    v = 16'($urandom);
    if (dsz == 1) exp_disp = {{8{v[7]}}, v[7:0]};
    if (dsz == 2) exp_disp = v;
    for (int i = 0; i < dsz; i++) begin mem[a + 16'(n)] = v[8*i +: 8]; n++; end
    v = 16'($urandom);
    if (isz == 1) exp_imm = {8'd0, v[7:0]};
    if (isz == 2) exp_imm = v;
    for (int i = 0; i < isz; i++) begin mem[a + 16'(n)] = v[8*i +: 8]; n++; end
    exp_len = 4'(n);
  endtask

  task automatic run_rand();
    int cyc;
    cyc = 0;
    while (!bus.instr_valid && cyc < 400) begin
      ce_1 = ($urandom_range(0, 3) != 0);
      bus.ipq_len = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
      step();
      cyc++;
    end
    chk("rand valid", bus.instr_valid, 1'b1);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      ce_1 = $urandom_range(0, 1) != 0;
      step();
    end
    chk("rand ip", bus.instr_ip, exp_ip);
    chk("rand len", bus.instr_len, exp_len);
    chk("rand head", bus.ipq_head, exp_ip + 16'(exp_len));
    chk("rand op", bus.op_out, exp_op);
    chk("rand seg", bus.seg_ovr, exp_seg);
    chk("rand rep", bus.rep_pfx, exp_rep);
    chk("rand lock", bus.lock_pfx, exp_lock);
    chk("rand modrm", bus.modrm, exp_modrm);
    chk("rand disp", bus.disp, exp_disp);
    chk("rand imm", bus.imm, exp_imm);
    chk("rand fault", bus.pfx_fault, 1'b0);
    accept();
  endtask

  initial begin
    reset = 1'b1; ce_1 = 1'b0;
    bus.ipq_len = 4'd0; bus.branch_req = 1'b0; bus.branch_ip = 16'd0; bus.instr_ready = 1'b0;
    put(16'h0000, 64'h2E8B46FC, 4);
    put(16'h0004, 64'hB83412, 3);
    put(16'h0007, 64'h8B867856, 4);
    put(16'h000B, 64'h81C01111, 4);
    step(); step();
    reset = 1'b0;
    chk("reset head", bus.ipq_head, 16'h0000);
    chk("reset pfp", bus.pfp_set, 1'b1);
    chk("reset valid", bus.instr_valid, 1'b0);
    chk("reset len", bus.instr_len, 4'd0);
    chk("reset disp", bus.disp, 16'd0);
    take_n(1);
    chk("pfp after first step", bus.pfp_set, 1'b0);
    chk("no take during pfp", bus.ipq_head, 16'h0000);

    // 2E 8B 46 FC: segment prefix, ModR/M with 8-bit displacement
    take_n(3);
    chk("modrm instr not yet valid", bus.instr_valid, 1'b0);
    take_n(1);
    chk("modrm instr valid", bus.instr_valid, 1'b1);
    chk("modrm instr seg", bus.seg_ovr, 3'b101);
    chk("modrm instr modrm", bus.modrm, 8'h46);
    chk("modrm instr disp", bus.disp, 16'hFFFC);
    chk("modrm instr len", bus.instr_len, 4'd4);
    chk("modrm instr head", bus.ipq_head, 16'h0004);
    chk("modrm instr ip", bus.instr_ip, 16'h0000);
    accept();

    // B8 34 12 then held for 5 steps
    take_n(3);
    chk("imm16 imm", bus.imm, 16'h1234);
    chk("imm16 len", bus.instr_len, 4'd3);
    for (int i = 0; i < 5; i++) begin
      take_n(1);
      chk("hold valid", bus.instr_valid, 1'b1);
      chk("hold imm", bus.imm, 16'h1234);
      chk("hold head", bus.ipq_head, 16'h0007);
    end
    accept();

    // 8B 86 78 56 with an empty queue in the middle of the displacement
    take_n(2);
    for (int i = 0; i < 3; i++) begin
      ce_1 = 1'b1; bus.ipq_len = 4'd0; step();
      chk("stall head", bus.ipq_head, 16'h0009);
      chk("stall valid", bus.instr_valid, 1'b0);
    end
    take_n(2);
    chk("stall disp", bus.disp, 16'h5678);
    chk("stall len", bus.instr_len, 4'd4);
    chk("stall end head", bus.ipq_head, 16'h000B);
    accept();

    // branch after 2 bytes of 81 C0 11 11
    take_n(2);
    put(16'h0100, 64'h90, 1);
    bus.branch_req = 1'b1; bus.branch_ip = 16'h0100; take_n(1); bus.branch_req = 1'b0;
    chk("branch pfp", bus.pfp_set, 1'b1);
    chk("branch head", bus.ipq_head, 16'h0100);
    chk("branch valid", bus.instr_valid, 1'b0);
    chk("branch drop len", bus.instr_len, 4'd0);
    take_n(1);
    chk("branch pfp one step", bus.pfp_set, 1'b0);
    chk("branch no take", bus.ipq_head, 16'h0100);
    chk("branch still not valid", bus.instr_valid, 1'b0);
    take_n(1);
    chk("post-branch valid", bus.instr_valid, 1'b1);
    chk("post-branch ip", bus.instr_ip, 16'h0100);
    chk("post-branch len", bus.instr_len, 4'd1);

    // branch and instr_ready together: branch wins; target wraps through FFFF
    put(16'hFFFE, 64'hB83412, 3);
    bus.branch_req = 1'b1; bus.branch_ip = 16'hFFFE; bus.instr_ready = 1'b1;
    take_n(1);
    bus.branch_req = 1'b0; bus.instr_ready = 1'b0;
    chk("branch+ready valid", bus.instr_valid, 1'b0);
    chk("branch+ready pfp", bus.pfp_set, 1'b1);
    chk("branch+ready head", bus.ipq_head, 16'hFFFE);
    take_n(4);
    chk("wrap valid", bus.instr_valid, 1'b1);
    chk("wrap imm", bus.imm, 16'h1234);
    chk("wrap ip", bus.instr_ip, 16'hFFFE);
    chk("wrap head", bus.ipq_head, 16'h0001);
    chk("wrap len", bus.instr_len, 4'd3);
    accept();

    cur = 16'h0001;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        tgt = 16'($urandom);
        ce_1 = 1'b1; bus.branch_req = 1'b1; bus.branch_ip = tgt;
        step();
        bus.branch_req = 1'b0;
        chk("rand branch pfp", bus.pfp_set, 1'b1);
        chk("rand branch head", bus.ipq_head, tgt);
        cur = tgt;
      end
      gen_instr(cur);
      run_rand();
      cur = cur + 16'(exp_len);
    end

    // 15 prefixes + opcode: fault on the fifth prefix, length saturates at 15
    put(cur, 64'h262EF3F03E, 5);
    for (int i = 0; i < 5; i++) put(cur + 16'(5 + 2*i), 64'hF236, 2);
    put(cur + 16'd15, 64'h90, 1);
    take_n(4);
    chk("fault after 4 prefixes", bus.pfx_fault, 1'b0);
    take_n(1);
    chk("fault after 5 prefixes", bus.pfx_fault, 1'b1);
    take_n(11);
    chk("long valid", bus.instr_valid, 1'b1);
    chk("long len saturates", bus.instr_len, 4'hF);
    chk("long head", bus.ipq_head, cur + 16'd16);
    chk("long ip", bus.instr_ip, cur);
    chk("long seg last wins", bus.seg_ovr, 3'b110);
    chk("long rep last wins", bus.rep_pfx, 3'b100);
    chk("long lock", bus.lock_pfx, 1'b1);
    accept();
    chk("fault sticky", bus.pfx_fault, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
